// File: rtl/level_tick_gen_pkg.sv
// Shared constants and the level-to-divisor mapping for level_tick_gen.
// Latency: n/a (package: constants and a pure function).
// Backpressure: n/a.
//
// Contents:
//   DFLT_* : default parameter values (board-clock based divisors, widths)
//   div_of : half-period in clk cycles for a given level
package clock_div_pkg;

    localparam int unsigned DFLT_LVL_W     = 4;
    localparam int unsigned DFLT_CNT_W     = 32;
    localparam int unsigned DFLT_MAX_LEVEL = 8;
    localparam int unsigned DFLT_BASE_DIV  = 38000000;
    localparam int unsigned DFLT_STEP_DIV  = 2000000;
    localparam int unsigned DFLT_FLOOR_DIV = 22000000;
    localparam int unsigned DFLT_MOVE_DIV  = 8000000;

    // Levels 1..max_level speed up linearly; level 0 and anything above
    // max_level fall back to the floor divisor.
    function automatic logic [31:0] div_of(
        input logic [31:0] lvl,
        input logic [31:0] max_level,
        input logic [31:0] base,
        input logic [31:0] step,
        input logic [31:0] floor_div
    );
        if ((lvl >= 32'd1) && (lvl <= max_level)) begin
            return base - ((lvl - 32'd1) * step);
        end
        return floor_div;
    endfunction

endpackage

// File: rtl/level_tick_gen_half_period_ctr.sv
// Half-period counter: counts div cycles, then toggles a square wave and pulses tick.
// Latency: wave/tick registered; tick is high in the cycle the wave toggles.
// Backpressure: none; pause freezes count and wave, restart (priority) clears both.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   div        : half-period in cycles (held stable by the parent between terms)
//   restart    : synchronous clear of counter and wave
//   pause      : hold counter and wave, suppress tick
//   wave       : 50%-duty square wave
//   tick       : one-cycle pulse per wave edge
//   term       : combinational, high when this cycle's edge will toggle the wave
module half_period_ctr #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div,
    input  logic             restart,
    input  logic             pause,
    output logic             wave,
    output logic             tick,
    output logic             term
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;
    logic             tick_q, tick_d;
    logic             at_last;

    assign at_last = (cnt_q == (div - CNT_W'(1)));
    // Restart and pause both beat the terminal count.
    assign term    = at_last && !restart && !pause;

    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        tick_d = 1'b0;
        if (restart) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (pause) begin
            cnt_d  = cnt_q;
        end else if (at_last) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
            tick_q <= tick_d;
        end
    end

    assign wave = wave_q;
    assign tick = tick_q;

endmodule

// File: rtl/level_tick_gen.sv
// Level-dependent game timebase plus fixed movement timebase, each as square wave and tick.
// Latency: outputs registered; first toggle div_active cycles after reset/restart.
// Backpressure: none; pause freezes both timebases, restart re-arms them with the current level.
//
// Ports:
//   clk, rst_n             : board clock, asynchronous active-low reset
//   curr_level [LVL_W]     : level, sampled only at half-period boundaries and on restart
//   pause, restart         : freeze / synchronous restart of both timebases
//   game_clk, game_tick    : level-dependent square wave and its edge pulse
//   move_clk, move_tick    : fixed square wave and its edge pulse
//   game_ticks [16]        : game_tick count, present only with TICK_COUNT_EN defined
module level_tick_gen
    import clock_div_pkg::*;
#(
    parameter int unsigned LVL_W     = DFLT_LVL_W,
    parameter int unsigned MAX_LEVEL = DFLT_MAX_LEVEL,
    parameter int unsigned BASE_DIV  = DFLT_BASE_DIV,
    parameter int unsigned STEP_DIV  = DFLT_STEP_DIV,
    parameter int unsigned FLOOR_DIV = DFLT_FLOOR_DIV,
    parameter int unsigned MOVE_DIV  = DFLT_MOVE_DIV,
    parameter int unsigned CNT_W     = DFLT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LVL_W-1:0] curr_level,
    input  logic             pause,
    input  logic             restart,
    output logic             game_clk,
    output logic             game_tick,
    output logic             move_clk,
    output logic             move_tick
`ifdef TICK_COUNT_EN
    ,
    output logic [15:0]      game_ticks
`endif
);

    // Reject configurations where any half-period would be zero (or wrap
    // negative at the top level) or would not fit in the counter.
    localparam longint unsigned CNT_LIMIT = longint'(1) << CNT_W;

    if ((BASE_DIV <= (MAX_LEVEL - 1) * STEP_DIV) || (FLOOR_DIV < 1) ||
        (MOVE_DIV < 1) || (MAX_LEVEL < 1) ||
        (longint'(BASE_DIV) >= CNT_LIMIT) || (longint'(FLOOR_DIV) >= CNT_LIMIT) ||
        (longint'(MOVE_DIV) >= CNT_LIMIT)) begin : g_bad_cfg
        $error("level_tick_gen: divisor configuration out of range");
    end

    logic [CNT_W-1:0] lvl_div;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] move_div_q, move_div_d;
    logic             game_term;
    logic             move_term;

    assign lvl_div = CNT_W'(div_of(32'(curr_level), 32'(MAX_LEVEL), 32'(BASE_DIV),
                                   32'(STEP_DIV), 32'(FLOOR_DIV)));

    // Level shadow: only the level present on a boundary (or on restart)
    // takes effect, so mid-half-period changes never stretch or cut a period.
    // The movement divisor goes through the same shadow path so both
    // timebases behave identically; with a constant reload it folds away.
    always_comb begin
        div_active_d = div_active_q;
        move_div_d   = move_div_q;
        if (restart || game_term) begin
            div_active_d = lvl_div;
        end
        if (restart || move_term) begin
            move_div_d = CNT_W'(MOVE_DIV);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_active_q <= CNT_W'(BASE_DIV);
            move_div_q   <= CNT_W'(MOVE_DIV);
        end else begin
            div_active_q <= div_active_d;
            move_div_q   <= move_div_d;
        end
    end

    half_period_ctr #(
        .CNT_W (CNT_W)
    ) u_game_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .div     (div_active_q),
        .restart (restart),
        .pause   (pause),
        .wave    (game_clk),
        .tick    (game_tick),
        .term    (game_term)
    );

    half_period_ctr #(
        .CNT_W (CNT_W)
    ) u_move_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .div     (move_div_q),
        .restart (restart),
        .pause   (pause),
        .wave    (move_clk),
        .tick    (move_tick),
        .term    (move_term)
    );

`ifdef TICK_COUNT_EN
    logic [15:0] ticks_q, ticks_d;

    // Counts on the same edge that raises game_tick; wraps naturally.
    always_comb begin
        ticks_d = ticks_q;
        if (restart) begin
            ticks_d = '0;
        end else if (game_term) begin
            ticks_d = ticks_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ticks_q <= '0;
        end else begin
            ticks_q <= ticks_d;
        end
    end

    assign game_ticks = ticks_q;
`endif

endmodule

// File: tb/tb_level_tick_gen.sv
module tb_level_tick_gen;

    localparam int LVL_W     = 4;
    localparam int MAX_LEVEL = 4;
    localparam int BASE      = 10;
    localparam int STEP      = 2;
    localparam int FLOOR     = 3;
    localparam int MOVE      = 4;
    localparam int CNT_W     = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [LVL_W-1:0] curr_level = 4'd1;
    logic             pause = 1'b0;
    logic             restart = 1'b0;
    logic             game_clk, game_tick, move_clk, move_tick;
`ifdef TICK_COUNT_EN
    logic [15:0]      game_ticks;
`endif

    always #5 clk = ~clk;

    level_tick_gen #(
        .LVL_W     (LVL_W),
        .MAX_LEVEL (MAX_LEVEL),
        .BASE_DIV  (BASE),
        .STEP_DIV  (STEP),
        .FLOOR_DIV (FLOOR),
        .MOVE_DIV  (MOVE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .curr_level (curr_level),
        .pause      (pause),
        .restart    (restart),
        .game_clk   (game_clk),
        .game_tick  (game_tick),
        .move_clk   (move_clk),
        .move_tick  (move_tick)
`ifdef TICK_COUNT_EN
        ,
        .game_ticks (game_ticks)
`endif
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int ref_div(input int lvl);
        if (lvl >= 1 && lvl <= MAX_LEVEL) return BASE - (lvl - 1) * STEP;
        return FLOOR;
    endfunction

    // Reference model: cycles remaining until each timebase's next edge.
    int g_rem, m_rem;
    bit g_clk_m, g_tick_m, m_clk_m, m_tick_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_rem = BASE; m_rem = MOVE;
            g_clk_m = 0; g_tick_m = 0; m_clk_m = 0; m_tick_m = 0;
        end else if (restart) begin
            g_rem = ref_div(int'(curr_level)); m_rem = MOVE;
            g_clk_m = 0; g_tick_m = 0; m_clk_m = 0; m_tick_m = 0;
        end else if (pause) begin
            g_tick_m = 0; m_tick_m = 0;
        end else begin
            g_rem--;
            g_tick_m = (g_rem == 0);
            if (g_rem == 0) begin
                g_clk_m = !g_clk_m;
                g_rem = ref_div(int'(curr_level));
            end
            m_rem--;
            m_tick_m = (m_rem == 0);
            if (m_rem == 0) begin
                m_clk_m = !m_clk_m;
                m_rem = MOVE;
            end
        end
    end

    always @(negedge clk) begin
        check("outputs_vs_model", int'({game_clk, game_tick, move_clk, move_tick}),
              int'({g_clk_m, g_tick_m, m_clk_m, m_tick_m}));
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count edges until game_tick is seen; -1 if the bound expires.
    task automatic measure_n(output int n);
        int k;
        k = 0;
        n = -1;
        while (k < 100) begin
            cyc();
            k++;
            if (game_tick) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic measure(input string name, input int exp);
        int n;
        measure_n(n);
        check(name, n, exp);
    endtask

    task automatic pulse_restart(input logic [LVL_W-1:0] lvl);
        curr_level = lvl;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    typedef struct {
        logic [LVL_W-1:0] level;
        int               exp_half;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        tbl[0] = '{4'd1, 10};
        tbl[1] = '{4'd2, 8};
        tbl[2] = '{4'd3, 6};
        tbl[3] = '{4'd4, 4};
        tbl[4] = '{4'd0, 3};
        tbl[5] = '{4'd9, 3};

        #12;
        check("reset_outputs", int'({game_clk, game_tick, move_clk, move_tick}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        measure("lvl1_first_half", 10);
        measure("lvl1_second_half", 10);

        // Level sweep
        for (int i = 0; i < 6; i++) begin
            pulse_restart(tbl[i].level);
            measure($sformatf("sweep_lvl%0d_first", tbl[i].level), tbl[i].exp_half);
            measure($sformatf("sweep_lvl%0d_second", tbl[i].level), tbl[i].exp_half);
        end

        // Level change mid-half-period is shadowed
        pulse_restart(4'd1);
        repeat (5) cyc();
        curr_level = 4'd4;
        measure_n(n);
        check("shadow_current_half", (n < 0) ? -1 : 5 + n, 10);
        measure("shadow_next_half", 4);

        // Pause at counter 8 for 7 cycles
        pulse_restart(4'd1);
        repeat (8) cyc();
        pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            check("pause_no_tick", int'(game_tick), 0);
        end
        pause = 1'b0;
        measure_n(n);
        check("pause_release_delay", n, 2);
        check("pause_total_half", (n < 0) ? -1 : 15 + n, 17);

        // Restart in the terminal cycle
        pulse_restart(4'd1);
        measure("restart_pre_half", 10);
        repeat (9) cyc();
        pulse_restart(4'd3);
        check("restart_term_no_tick", int'(game_tick), 0);
        check("restart_term_clk_low", int'(game_clk), 0);
        measure("restart_next_half", 6);

        // Asynchronous reset mid-period
        pulse_restart(4'd1);
        measure("prereset_half", 10);
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({game_clk, game_tick, move_clk, move_tick}), 0);
        curr_level = 4'd2;
        @(negedge clk);
        rst_n = 1'b1;
        measure("postreset_first_half", 10);
        measure("postreset_second_half", 8);

        // Randomised run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) curr_level = LVL_W'($urandom_range(0, 15));
            pause   = ($urandom_range(0, 9) == 0);
            restart = ($urandom_range(0, 59) == 0);
            cyc();
        end
        pause = 1'b0;
        restart = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/level_tick_gen.md
Name: level_tick_gen

Overview:
Parametrised successor to the game clock divider. Produces a level-dependent game timebase and a fixed movement timebase from the board clock. Each timebase is available both as a 50%-duty square wave and as a one-cycle tick enable.
Adds level shadowing at period boundaries, pause, synchronous restart and an out-of-range level floor. Sits between the level/score FSM and the game, movement and render logic.

Parameters:
LVL_W, 4, width of curr_level
MAX_LEVEL, 8, highest level with its own divisor; must satisfy 1 <= MAX_LEVEL < 2**LVL_W
BASE_DIV, 38000000, half-period in clk cycles at level 1
STEP_DIV, 2000000, half-period reduction per level above 1
FLOOR_DIV, 22000000, half-period for level 0 and for levels > MAX_LEVEL
MOVE_DIV, 8000000, fixed half-period of the movement timebase
CNT_W, 32, counter width; every divisor must fit in CNT_W bits

Ports:
clk  in  1  board clock
rst_n  in  1  asynchronous active-low reset
curr_level  in  LVL_W  current game level
pause  in  1  freeze both timebases while high
restart  in  1  synchronous restart of both timebases (one-cycle pulse)
game_clk  out  1  level-dependent square wave
game_tick  out  1  one-cycle pulse per game_clk edge
move_clk  out  1  fixed square wave
move_tick  out  1  one-cycle pulse per move_clk edge

Behaviour:
- Divisor function div(L):
  - L in 1..MAX_LEVEL: BASE_DIV - (L-1)*STEP_DIV
  - otherwise: FLOOR_DIV
  - Elaboration-time check: div(MAX_LEVEL) >= 1, FLOOR_DIV >= 1, MOVE_DIV >= 1.
- Reset (rst_n low, async): both counters 0, game_clk=0, move_clk=0, game_tick=0, move_tick=0, div_active=BASE_DIV.
- Game counter, per cycle, priority restart > pause > count:
  - restart: counter <= 0, game_clk <= 0, game_tick <= 0, div_active <= div(curr_level).
  - pause: counter, game_clk and div_active hold; game_tick <= 0.
  - counter == div_active-1: counter <= 0, game_clk toggles, game_tick <= 1 for exactly one cycle, div_active <= div(curr_level).
  - else: counter+1, game_tick <= 0.
- Timing:
  - The first game_clk rise after reset/restart occurs div_active cycles after counting starts; game_tick is high in that same cycle (registered, aligned with the toggle).
  - Half-period = div_active cycles; full period = 2*div_active.
- Level shadowing:
  - A curr_level change mid-half-period does not affect the current half-period; the new divisor applies from the next half-period.
  - Multiple level changes within one half-period: only the value present at the terminal cycle is used.
- Move counter: identical rules with the constant MOVE_DIV. It obeys the same restart/pause, but is independent of curr_level.
- pause asserted in the terminal cycle: no toggle and no tick; the toggle occurs in the first unpaused cycle.
- Simultaneous restart and terminal count: restart wins; no tick.
- Counters never exceed div_active-1 (no wrap through CNT_W).

Optional Feature:
Macro TICK_COUNT_EN.
- Defined: extra output game_ticks (16 bits). It increments on each game_tick, wraps 0xFFFF->0, and is cleared by reset and restart. Used by the score/level FSM for elapsed-time levelling.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package clock_div_pkg holds:
  - default constants (BASE_DIV, STEP_DIV, FLOOR_DIV, MOVE_DIV, MAX_LEVEL)
  - LVL_W and CNT_W widths
  - the div() function
- Sub-module half_period_ctr: counter + toggle + tick with inputs div, restart, pause. It is instantiated twice (game, move); the top holds div_active and the level mapping.

Test Plan:
- Params BASE_DIV=10, STEP_DIV=2, MAX_LEVEL=4, FLOOR_DIV=3, MOVE_DIV=4; level=1 after reset -> game_clk toggles every 10 cycles, 1 game_tick per toggle; move_clk toggles every 4 cycles.
- Sweep levels 1..4 and levels 0 and 9 -> half-periods 10, 8, 6, 4, then 3 and 3.
- Level 1->4 at counter 5 -> current half-period still 10 cycles, next half-period 4.
- pause held 7 cycles at counter 8 -> no ticks during pause; toggle 2 cycles after release; total half-period 17.
- restart pulsed in the terminal cycle -> no tick; game_clk=0, counter=0; next toggle after div(curr_level) cycles.
- rst_n low mid-period (async, between clk edges) -> all outputs 0 immediately; after release, level 2 gives first toggle at 10 cycles (reset div), then 8.
